// File: rtl/cpu_controller.sv
// Phase-sequenced control unit for an 8-phase instruction cycle with a sticky halt.
// Optional instruction counter is enabled by defining CTRL_INSTR_COUNT_EN.
module cpu_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       Enable,
  input  logic [2:0] Opcode,
  input  logic       Zero,
  output logic [2:0] Phase,
  output logic       Sel,
  output logic       Rd,
  output logic       Ld_ir,
  output logic       Inc_pc,
  output logic       Ld_pc,
  output logic       Ld_ac,
  output logic       Wr,
  output logic       Data_e,
  output logic       Halt
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [7:0] Instr_count
`endif
);

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4,
    PH5 = 3'd5,
    PH6 = 3'd6,
    PH7 = 3'd7
  } phase_t;

  phase_t phase_q;
  logic   halted_q;
  logic   run_q;
  logic   is_hlt;
  logic   is_skz;
  logic   is_sto;
  logic   is_jmp;
  logic   aluop;
  logic   step;

  assign is_hlt = (Opcode == OP_HLT);
  assign is_skz = (Opcode == OP_SKZ);
  assign is_sto = (Opcode == OP_STO);
  assign is_jmp = (Opcode == OP_JMP);
  assign aluop  = (Opcode == OP_ADD) || (Opcode == OP_AND) ||
                  (Opcode == OP_XOR) || (Opcode == OP_LDA);

  // run_q swallows the first edge after reset release so phase 0 is held once.
  assign step = run_q && Enable && !halted_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH0;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (step) begin
        if (phase_q == PH4 && is_hlt) begin
          halted_q <= 1'b1;
        end else begin
          phase_q <= phase_t'(phase_q + 3'd1);
        end
      end
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else if (step && phase_q == PH7) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign Instr_count = count_q;
`endif

  assign Phase = phase_q;

  always_comb begin
    Sel    = 1'b0;
    Rd     = 1'b0;
    Ld_ir  = 1'b0;
    Inc_pc = 1'b0;
    Ld_pc  = 1'b0;
    Ld_ac  = 1'b0;
    Wr     = 1'b0;
    Data_e = 1'b0;
    Halt   = 1'b0;
    if (halted_q) begin
      Halt = 1'b1;
    end else begin
      unique case (phase_q)
        PH0: Sel = 1'b1;
        PH1: begin
          Sel = 1'b1;
          Rd  = 1'b1;
        end
        PH2, PH3: begin
          Sel   = 1'b1;
          Rd    = 1'b1;
          Ld_ir = 1'b1;
        end
        PH4: begin
          Inc_pc = 1'b1;
          Halt   = is_hlt;
        end
        PH5: Rd = aluop;
        PH6: begin
          Rd     = aluop;
          Inc_pc = is_skz && Zero;
          Ld_pc  = is_jmp;
          Data_e = is_sto;
        end
        PH7: begin
          Rd     = aluop;
          Ld_ac  = aluop;
          Inc_pc = is_jmp;
          Ld_pc  = is_jmp;
          Wr     = is_sto;
          Data_e = is_sto;
        end
        default: Sel = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have these ports; `clock` and `reset` come first:
- `clock`, input, 1 bit: single clock; all state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `Enable`, input, 1 bit: when 1, the phase sequencer advances; when 0, it holds.
- `Opcode`, input, 3 bits: from the instruction register. HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- `Zero`, input, 1 bit: accumulator-is-zero flag from the ALU.
- `Phase`, output, 3 bits: current phase, 0..7.
- `Sel`, output, 1 bit: address mux select; 1 = PC, 0 = IR operand.
- `Rd`, output, 1 bit: memory read.
- `Ld_ir`, output, 1 bit: load the instruction register.
- `Inc_pc`, output, 1 bit: drives the PC `En_cpu_in` input.
- `Ld_pc`, output, 1 bit: drives the PC `Load_in` input.
- `Ld_ac`, output, 1 bit: load the accumulator.
- `Wr`, output, 1 bit: memory write.
- `Data_e`, output, 1 bit: drive the data bus.
- `Halt`, output, 1 bit: CPU stopped.
REQ-002 There SHALL be no parameters.

Function
REQ-003 The phase register SHALL be 3 bits and SHALL advance by 1 per rising edge of `clock` when `Enable`=1, wrapping from 7 to 0.
REQ-004 When `Enable`=0, the phase register and the halted flag SHALL hold their values.
REQ-005 Outputs SHALL be combinational decodes of the phase, `Opcode`, `Zero` and the halted flag.
REQ-006 ALUOP SHALL be defined as `Opcode` in {ADD, AND, XOR, LDA}.
REQ-007 Output decode per phase; any output not listed in a phase is 0:
- Phase 0: `Sel`=1.
- Phase 1: `Sel`=1, `Rd`=1.
- Phase 2: `Sel`=1, `Rd`=1, `Ld_ir`=1.
- Phase 3: `Sel`=1, `Rd`=1, `Ld_ir`=1.
- Phase 4: `Inc_pc`=1; `Halt`=1 if `Opcode`=HLT.
- Phase 5: `Rd`=ALUOP.
- Phase 6: `Rd`=ALUOP; `Inc_pc`=(SKZ and `Zero`); `Ld_pc`=JMP; `Data_e`=STO.
- Phase 7: `Rd`=ALUOP; `Ld_ac`=ALUOP; `Inc_pc`=JMP; `Ld_pc`=JMP; `Wr`=STO; `Data_e`=STO.
REQ-008 The halted flag SHALL be set on the rising edge of `clock` at which phase=4, `Opcode`=HLT and `Enable`=1.
REQ-009 While halted, the phase SHALL freeze at 4, `Halt` SHALL be 1, and all other control outputs SHALL be 0 regardless of `Enable`.
REQ-010 Only `reset` SHALL clear the halted flag.
REQ-011 SKZ with `Zero`=0 SHALL produce no `Inc_pc` pulse in phase 6.
REQ-012 Each instruction SHALL produce exactly one `Inc_pc` pulse in phase 4, plus one additional pulse in phase 6 for SKZ taken or in phase 7 for JMP.
REQ-013 `Wr` and `Rd` SHALL never both be 1 in the same cycle.
REQ-014 An `Opcode` change in phases 0-3 SHALL be tolerated, because the decode only depends on `Opcode` in phases 4-7.

Reset
REQ-015 `reset`=0 SHALL asynchronously force phase=0 and the halted flag=0, and clear any counter.
REQ-016 During reset the outputs SHALL be: `Sel`=1, `Phase`=0, all other outputs 0.
REQ-017 Reset asserted mid-instruction SHALL abort the instruction immediately; no `Wr` or `Ld_pc` pulse SHALL occur after `reset` falls.
REQ-018 Release of `reset` SHALL be synchronous in effect: phase 0 SHALL be held through the first rising edge after release and advance on the next one.

Configuration
REQ-019 Macro `CTRL_INSTR_COUNT_EN`, when defined, SHALL add the output `Instr_count` (8 bits, reset 0).
- `Instr_count` SHALL increment by 1 on each enabled phase 7->0 transition.
- It SHALL wrap from 255 to 0.
- It SHALL hold while halted or when `Enable`=0.
REQ-020 When `CTRL_INSTR_COUNT_EN` is undefined, the `Instr_count` port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Reset: assert `reset`=0 at phase 5 -> `Phase`=0 immediately, `Sel`=1, all other outputs 0; after release, `Phase` reaches 1 on the 2nd edge.
REQ-022 ADD sequence: `Opcode`=010, `Enable`=1 for 8 cycles ->
- `Rd` is 1 in phases 1, 2, 3, 5, 6 and 7.
- `Ld_ac`=1 only in phase 7.
- `Inc_pc`=1 only in phase 4.
REQ-023 SKZ: `Opcode`=001 -> with `Zero`=1, `Inc_pc` pulses in phases 4 and 6; with `Zero`=0, `Inc_pc` pulses only in phase 4.
REQ-024 JMP and STO:
- `Opcode`=111 -> `Ld_pc`=1 in phases 6 and 7, `Inc_pc`=1 in phases 4 and 7.
- `Opcode`=110 -> `Data_e`=1 in phases 6 and 7, `Wr`=1 only in phase 7.
REQ-025 HLT: `Opcode`=000 -> at phase 4, `Halt`=1 and `Phase` stays 4 for 20 cycles with `Enable`=1; a `reset` pulse returns `Phase` to 0 with `Halt`=0.
REQ-026 Enable and counter:
- `Enable`=0 for 5 cycles at phase 3 -> `Phase` stays 3 and outputs are stable.
- With `CTRL_INSTR_COUNT_EN` defined, 257 ADD instructions -> `Instr_count`=1.
